// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared state encoding and default sizes for the rv32i data-memory responder.
package rv32i_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 1024;
  localparam int DATA_W     = 32;
endpackage

// File: rtl/rv32i_dmem_array.sv
// rv32i_dmem_array: synchronous single-port DEPTH x 32 word storage with registered read.
// Optional even-parity column under DMEM_PARITY_EN.
module rv32i_dmem_array
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              par_err_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
    if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
`ifdef DMEM_PARITY_EN
  logic par_q [DEPTH];
  logic par_err_q;
  always_ff @(posedge clk) begin
    if (en_i && we_i) par_q[addr_i] <= ^wdata_i;
    if (en_i && !we_i) par_err_q <= par_q[addr_i] != ^mem_q[addr_i];
  end
  assign par_err_o = par_err_q;
`else
  assign par_err_o = 1'b0;
`endif
endmodule

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: valid/ready data-memory slave with WAIT_CYCLES wait states.
// Parity checking is enabled by defining DMEM_PARITY_EN.
module rv32i_dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_ok_q, rd_ok_d;
  logic              err_q, err_d;
  logic              accept, access, in_range, par_err;
  logic [DATA_W-1:0] arr_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_ok_q <= rd_ok_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE && req_valid) ? WAIT :
              access                         ? RESP :
              (state_q == RESP && rsp_ready) ? IDLE : state_q;
    cnt_d   = accept ? 4'(WAIT_CYCLES) :
              (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    we_d    = accept ? req_we : we_q;
    addr_d  = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rd_ok_d = access ? (!we_q && in_range) : rd_ok_q;
    err_d   = access ? !in_range : err_q;
  end
  always_comb begin
    req_ready = state_q == IDLE;
    rsp_valid = state_q == RESP;
    accept    = req_valid && req_ready;
    access    = state_q == WAIT && cnt_q == 4'd0;
    in_range  = {1'b0, addr_q} < DEPTH_L;
    rsp_rdata = rd_ok_q ? arr_rdata : '0;
    rsp_err   = err_q || (rd_ok_q && par_err);
  end
  // Out-of-range accesses never reach the array, so they cannot write or read.
  rv32i_dmem_array #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_arr (
    .clk      (clk),
    .en_i     (access && in_range),
    .we_i     (we_q),
    .addr_i   (addr_q),
    .wdata_i  (wdata_q),
    .rdata_o  (arr_rdata),
    .par_err_o(par_err)
  );
endmodule
